// File: rtl/count_display_scan_pkg.sv
// Shared types and constants for the count display scanner: glyph table,
// blanking code, digit index type and the two-digit BCD wrap counter.
package count_display_scan_pkg;

   localparam int unsigned CNT_W           = 4;
   localparam int unsigned SEG_W           = 7;
   localparam int unsigned AN_W            = 4;
   localparam int unsigned BCD_W           = 8;
   localparam int unsigned MAX_VAL_DEFAULT = 10;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} glyphs, index 15 first so HEX_GLYPHS[n] is digit n.
   localparam logic [15:0][SEG_W-1:0] HEX_GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef logic [1:0] digit_idx_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   // 00..99 BCD increment, rolling 99 over to 00.
   function automatic bcd2_t bcd2_inc(input bcd2_t v);
      bcd2_t r;
      r = v;
      if (v.ones == 4'd9) begin
         r.ones = 4'd0;
         r.tens = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
      end else begin
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
   import count_display_scan_pkg::*;
(
   input  logic [CNT_W-1:0] nibble_i,
   output logic [SEG_W-1:0] seg_o_c
);

   assign seg_o_c = HEX_GLYPHS[nibble_i];

endmodule

// File: rtl/count_display_scan.sv
// Resynchronises and filters the upstream count, counts wraps to zero in BCD
// and scans the values onto a 4-digit multiplexed active-low display.
module count_display_scan
   import count_display_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned MAX_VAL  = MAX_VAL_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt_in,
   output logic [SEG_W-1:0] seg,
   output logic [AN_W-1:0]  an,
   output logic [BCD_W-1:0] wrap_bcd,
   output logic             err
);

   localparam int unsigned        PRESC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0]   s1_q, s2_q, s3_q;
   logic [CNT_W-1:0]   cur_val_q, cur_val_d;
   bcd2_t              wrap_q, wrap_d;
   logic               err_q, err_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   digit_idx_t         idx_q, idx_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic [AN_W-1:0]    an_q, an_d;

   logic               load_c;
   logic [CNT_W-1:0]   nibble_c;
   logic               blank_c;
   logic [SEG_W-1:0]   glyph_c;

   // Three-flop resync; a value is accepted once two consecutive samples agree.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= cnt_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Filtered value, wrap counter and sticky range error.
   always_comb begin
      load_c    = (s2_q == s3_q);
      cur_val_d = cur_val_q;
      wrap_d    = wrap_q;
      err_d     = err_q;
      if (load_c) begin
         cur_val_d = s2_q;
         if ((s2_q == '0) && (cur_val_q != '0)) begin
            wrap_d = bcd2_inc(wrap_q);
         end
         if (32'(s2_q) > MAX_VAL) begin
            err_d = 1'b1;
         end
      end
   end

   // Digit slot prescaler and index.
   always_comb begin
      presc_d = presc_q + PRESC_W'(1);
      idx_d   = idx_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end
   end

   // Select the nibble for the current slot; tens digit blanks its leading zero.
   always_comb begin
      nibble_c = cur_val_q;
      blank_c  = 1'b0;
      case (idx_q)
         2'd0:    nibble_c = cur_val_q;
         2'd1:    nibble_c = wrap_q.ones;
         2'd2: begin
            nibble_c = wrap_q.tens;
            blank_c  = (wrap_q.tens == 4'd0);
         end
         default: blank_c = 1'b1;
      endcase
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble_i (nibble_c),
      .seg_o_c  (glyph_c)
   );

   // Anode and segments come from the same idx_q so they always switch together.
   always_comb begin
      seg_d = blank_c ? SEG_BLANK : glyph_c;
      an_d  = ~(AN_W'(1) << idx_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_val_q <= '0;
         wrap_q    <= '0;
         err_q     <= 1'b0;
         presc_q   <= '0;
         idx_q     <= '0;
         seg_q     <= SEG_BLANK;
         an_q      <= '1;
      end else begin
         cur_val_q <= cur_val_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign seg      = seg_q;
   assign an       = an_q;
   assign wrap_bcd = wrap_q;
   assign err      = err_q;

endmodule

// File: doc/count_display_scan.md
Name: count_display_scan

Overview:
- Downstream consumer of the divided-clock count value (0..10, wraps 10->0) produced by the sync-counter stage.
- Resynchronises that count into the fast clk domain and filters it for stability.
- Counts wrap events (any value -> 0) in a two-digit BCD counter.
- Drives a 4-digit multiplexed, active-low 7-segment display: digit0 = current count (hex glyph), digit1/digit2 = wrap count ones/tens, digit3 = blank.

Parameters:
- SCAN_DIV, 4: clk cycles per digit slot; >=1; board builds use ~50000.
- MAX_VAL, 10: largest legal input value; above this sets err.

Ports:
- clk  in  1  system clock, same source as the upstream divider.
- rst  in  1  asynchronous, active-low reset.
- cnt_in  in  4  count from the upstream stage; changes on its divided clock, treated as asynchronous.
- seg  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- an  out  4  digit enables, active-low, one-hot-zero, registered.
- wrap_bcd  out  8  {tens,ones} BCD wrap count, 00..99.
- err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (rst=0, async): s1=s2=s3=0, cur_val=0, wrap_bcd=8'h00, err=0, presc=0, idx=0, seg=7'h7F, an=4'hF. Reset mid-operation aborts the scan and clears the wrap count immediately.
- Sync/filter:
  - s1<=cnt_in; s2<=s1; s3<=s2.
  - cur_val<=s2 when s2==s3.
  - A change held stable is reflected in cur_val on the 4th rising edge after cnt_in changes.
  - A change shorter than 2 clk is never accepted.
- Wrap detect:
  - Fires in the cycle cur_val is loaded with 0 while old cur_val!=0.
  - On fire, wrap_bcd increments in BCD: ones 9->0 with tens+1; 99->00.
  - wrap_bcd updates on the same edge as cur_val.
  - Repeated acceptance of 0 is not a wrap.
- err: set on the edge cur_val is loaded with a value >MAX_VAL. Cleared only by rst. The value is still displayed.
- Scan:
  - presc counts 0..SCAN_DIV-1, then wraps.
  - When presc==SCAN_DIV-1, idx advances 0->1->2->3->0.
  - an<=~(4'b0001<<idx) every edge, so an=4'b1110 after the first edge out of reset.
  - seg<=glyph(idx) on the same edge; an and seg are always coherent, with no ghosting cycle.
- Glyphs:
  - idx0: hex(cur_val).
  - idx1: hex(wrap ones).
  - idx2: hex(wrap tens), or blank 7'h7F when tens==0 (leading-zero blank).
  - idx3: 7'h7F.
  - Display lags cur_val/wrap_bcd by 1 clk.
- Hex table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Widths: presc is clog2(SCAN_DIV) bits, minimum 1; idx is 2 bits and wraps naturally.
- Simultaneous events: a wrap and a digit advance on the same edge are independent. The new digit shows the pre-update wrap_bcd, and the next scan shows the new value.

Decomposition:
- Shared package holds:
  - SEG_BLANK=7'h7F.
  - The 16-entry hex glyph constants.
  - Default MAX_VAL.
  - A 2-bit digit-index typedef.
- One combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out), instantiated once on the muxed digit nibble.
- Sync/filter, wrap BCD counter and scan all stay in the top block.

Test Plan:
- Reset: hold rst=0 with cnt_in=7 -> seg=7F, an=F, wrap_bcd=00, err=0. Release: after 1 edge an=1110, seg=40.
- Step 0->5 held: cur_val=5 on the 4th edge. Next idx0 slot shows an=1110, seg=12. idx3 slot shows an=0111, seg=7F.
- Sequence 0,1..10,0, each held 8 clk -> one wrap, wrap_bcd=01. idx1 slot seg=79; idx2 slot seg=7F (blanked). The value 10 displays seg=08.
- 100 full sequences -> wrap_bcd passes 09->10 (idx2 seg=79) and reaches 99 then 00.
- 1-clk glitch 3->6->3 on cnt_in -> cur_val stays 3, no wrap, err stays 0. Glitch 5->0->5 -> wrap_bcd unchanged.
- cnt_in=12 held -> err=1, idx0 seg=46. Return to 0 -> err stays 1 and wrap counts. Assert rst mid-scan -> all outputs return to reset values immediately.
